lbb_lbus_slave: RTL and testbench

Local-bus slave front end for the LBB FPGA. It decodes i960-style local-bus cycles on I_LCLK (ADS/LWR/BLAST/LBE/LAD), claims cycles selected by I_LABS3, and converts each data beat into a single-word request/acknowledge transaction toward the downstream TCI sequencer. It returns read data on LAD, paces the host with ON_READYi, and bounds every beat with a timeout.

---
 rtl/lbb_pkg.sv | 32 +++
 rtl/lbb_lbus_slave_if.sv | 43 ++++
 rtl/lbb_beat_timer.sv | 34 +++
 rtl/lbb_lbus_slave.sv | 123 ++++++++++++
 tb/tb_lbb_lbus_slave.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbb_pkg.sv
// ============================================================================
// Module      : lbb_pkg
// Description : Shared types, widths and helpers for the LBB local-bus slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbb_pkg;

    localparam int LBB_AW = 32;
    localparam int LBB_DW = 32;

    localparam logic [LBB_DW-1:0] LBB_TO_RDATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_REQ     = 3'd2,
        ST_READY   = 3'd3,
        ST_RECOVER = 3'd4
    } lbb_lbus_state_t;

    // Bursts wrap inside the 16-byte-aligned quad: only word bits [3:2] advance.
    function automatic logic [LBB_AW-1:2] next_quad_addr(input logic [LBB_AW-1:2] word_addr);
        logic [1:0] w_lo;
        w_lo = word_addr[3:2] + 2'd1;
        return {word_addr[LBB_AW-1:4], w_lo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lbb_lbus_slave_if.sv
// ============================================================================
// Module      : lbb_lbus_slave_if
// Description : Local-bus pins plus downstream request/ack channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lbb_lbus_slave_if;
    import lbb_pkg::*;

    logic              IN_ADS;
    logic              I_LABS3;
    logic              IN_LWR;
    logic              IN_BLAST;
    logic [3:0]        IN_LBE;
    logic [LBB_DW-1:0] I_LAD;
    logic [LBB_DW-1:0] O_LAD;
    logic              O_LAD_OE;
    logic              ON_READYi;
    logic              O_REQ;
    logic              O_REQ_WR;
    logic [LBB_AW-1:0] O_REQ_ADDR;
    logic [3:0]        O_REQ_BE;
    logic [LBB_DW-1:0] O_REQ_WDATA;
    logic              I_REQ_ACK;
    logic [LBB_DW-1:0] I_RSP_RDATA;
    logic              O_TIMEOUT;

    modport slave (
        input  IN_ADS, I_LABS3, IN_LWR, IN_BLAST, IN_LBE, I_LAD, I_REQ_ACK, I_RSP_RDATA,
        output O_LAD, O_LAD_OE, ON_READYi, O_REQ, O_REQ_WR, O_REQ_ADDR, O_REQ_BE,
               O_REQ_WDATA, O_TIMEOUT
    );

    modport master (
        output IN_ADS, I_LABS3, IN_LWR, IN_BLAST, IN_LBE, I_LAD, I_REQ_ACK, I_RSP_RDATA,
        input  O_LAD, O_LAD_OE, ON_READYi, O_REQ, O_REQ_WR, O_REQ_ADDR, O_REQ_BE,
               O_REQ_WDATA, O_TIMEOUT
    );

endinterface

`default_nettype wire

// File: rtl/lbb_beat_timer.sv
// ============================================================================
// Module      : lbb_beat_timer
// Description : 8-bit per-beat wait counter; flags expiry at TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbb_beat_timer #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expired_o
);

    logic [7:0] cnt_q;

    assign expired_o = (cnt_q == TIMEOUT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else if (clear_i) begin
            cnt_q <= 8'd0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lbb_lbus_slave.sv
// ============================================================================
// Module      : lbb_lbus_slave
// Description : i960-style local-bus slave; one downstream request per beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbb_lbus_slave
    import lbb_pkg::*;
#(
    parameter logic [7:0]        TIMEOUT  = 8'd255,
    parameter logic [LBB_DW-1:0] TO_RDATA = LBB_TO_RDATA_DEFAULT
) (
    input  wire logic       I_LCLK,
    input  wire logic       IN_RESET,
    lbb_lbus_slave_if.slave bus
);

    lbb_lbus_state_t   state_q;
    logic [LBB_AW-1:2] addr_q;
    logic              wr_q;
    logic [3:0]        be_q;
    logic [LBB_DW-1:0] wdata_q;
    logic              req_q;
    logic              readyn_q;
    logic [LBB_DW-1:0] lad_q;
    logic              lad_oe_q;
    logic              timeout_q;
    logic              w_expired;

    lbb_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_timer (
        .clk_i     (I_LCLK),
        .rst_ni    (IN_RESET),
        .clear_i   (state_q == ST_ADDR),
        .enable_i  (state_q == ST_REQ),
        .expired_o (w_expired)
    );

    assign bus.O_REQ       = req_q;
    assign bus.O_REQ_WR    = wr_q;
    assign bus.O_REQ_ADDR  = {addr_q, 2'b00};
    assign bus.O_REQ_BE    = be_q;
    assign bus.O_REQ_WDATA = wdata_q;
    assign bus.ON_READYi   = readyn_q;
    assign bus.O_LAD       = lad_q;
    assign bus.O_LAD_OE    = lad_oe_q;
    assign bus.O_TIMEOUT   = timeout_q;

    always_ff @(posedge I_LCLK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= '0;
            req_q     <= 1'b0;
            readyn_q  <= 1'b1;
            lad_q     <= '0;
            lad_oe_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!bus.IN_ADS && bus.I_LABS3) begin
                        addr_q  <= bus.I_LAD[LBB_AW-1:2];
                        wr_q    <= ~bus.IN_LWR;
                        be_q    <= ~bus.IN_LBE;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    wdata_q <= bus.I_LAD;
                    be_q    <= ~bus.IN_LBE;
                    req_q   <= 1'b1;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    // A real ack on the expiry edge takes priority over the timeout.
                    if (bus.I_REQ_ACK) begin
                        req_q    <= 1'b0;
                        readyn_q <= 1'b0;
                        if (!wr_q) begin
                            lad_q    <= bus.I_RSP_RDATA;
                            lad_oe_q <= 1'b1;
                        end
                        state_q  <= ST_READY;
                    end else if (w_expired) begin
                        req_q     <= 1'b0;
                        readyn_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        if (!wr_q) begin
                            lad_q    <= TO_RDATA;
                            lad_oe_q <= 1'b1;
                        end
                        state_q   <= ST_READY;
                    end
                end
                ST_READY: begin
                    readyn_q <= 1'b1;
                    lad_oe_q <= 1'b0;
                    if (!bus.IN_BLAST) begin
                        state_q <= ST_RECOVER;
                    end else begin
                        addr_q  <= next_quad_addr(addr_q);
                        state_q <= ST_ADDR;
                    end
                end
                ST_RECOVER: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lbb_lbus_slave.sv
// ============================================================================
// Module      : tb_lbb_lbus_slave
// Description : Directed vector bench for the local-bus slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lbb_lbus_slave;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  lbe;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_lad;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [4];

    lbb_lbus_slave_if bus ();

    lbb_lbus_slave #(
        .TIMEOUT  (8'd255),
        .TO_RDATA (32'hFFFF_FFFF)
    ) dut (
        .I_LCLK   (clk),
        .IN_RESET (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic wr, input logic [31:0] addr, input logic [3:0] lbe);
        bus.IN_ADS  = 1'b0;
        bus.I_LABS3 = 1'b1;
        bus.IN_LWR  = ~wr;
        bus.IN_LBE  = lbe;
        bus.I_LAD   = addr;
        tick();
        bus.IN_ADS  = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},    {31'd0, bus.O_REQ},     32'd0);
        chk({tag, "_wr"},     {31'd0, bus.O_REQ_WR},  32'd0);
        chk({tag, "_addr"},   bus.O_REQ_ADDR,         32'd0);
        chk({tag, "_be"},     {28'd0, bus.O_REQ_BE},  32'd0);
        chk({tag, "_wdata"},  bus.O_REQ_WDATA,        32'd0);
        chk({tag, "_readyn"}, {31'd0, bus.ON_READYi}, 32'd1);
        chk({tag, "_lad"},    bus.O_LAD,              32'd0);
        chk({tag, "_oe"},     {31'd0, bus.O_LAD_OE},  32'd0);
        chk({tag, "_to"},     {31'd0, bus.O_TIMEOUT}, 32'd0);
    endtask

    task automatic run_single(input vec_t v, input int idx);
        start_cycle(v.wr, v.addr, v.lbe);
        chk($sformatf("v%0d_addr", idx), bus.O_REQ_ADDR, v.exp_addr);
        chk($sformatf("v%0d_req_addr_phase", idx), {31'd0, bus.O_REQ}, 32'd0);
        bus.I_LAD    = v.wdata;
        bus.IN_BLAST = 1'b0;
        tick();
        chk($sformatf("v%0d_req", idx), {31'd0, bus.O_REQ}, 32'd1);
        chk($sformatf("v%0d_wr", idx), {31'd0, bus.O_REQ_WR}, {31'd0, v.wr});
        chk($sformatf("v%0d_be", idx), {28'd0, bus.O_REQ_BE}, {28'd0, v.exp_be});
        if (v.wr)
            chk($sformatf("v%0d_wdata", idx), bus.O_REQ_WDATA, v.wdata);
        for (int i = 0; i < v.dly; i++) begin
            tick();
            chk($sformatf("v%0d_wait_req", idx), {31'd0, bus.O_REQ}, 32'd1);
            chk($sformatf("v%0d_wait_readyn", idx), {31'd0, bus.ON_READYi}, 32'd1);
            chk($sformatf("v%0d_wait_oe", idx), {31'd0, bus.O_LAD_OE}, 32'd0);
        end
        bus.I_REQ_ACK   = 1'b1;
        bus.I_RSP_RDATA = v.rdata;
        tick();
        bus.I_REQ_ACK   = 1'b0;
        chk($sformatf("v%0d_ready_readyn", idx), {31'd0, bus.ON_READYi}, 32'd0);
        chk($sformatf("v%0d_ready_req", idx), {31'd0, bus.O_REQ}, 32'd0);
        chk($sformatf("v%0d_ready_oe", idx), {31'd0, bus.O_LAD_OE}, {31'd0, ~v.wr});
        chk($sformatf("v%0d_ready_to", idx), {31'd0, bus.O_TIMEOUT}, 32'd0);
        if (!v.wr)
            chk($sformatf("v%0d_lad", idx), bus.O_LAD, v.exp_lad);
        tick();
        chk($sformatf("v%0d_recover_readyn", idx), {31'd0, bus.ON_READYi}, 32'd1);
        chk($sformatf("v%0d_recover_oe", idx), {31'd0, bus.O_LAD_OE}, 32'd0);
        bus.IN_BLAST = 1'b1;
        tick();
        chk($sformatf("v%0d_idle_req", idx), {31'd0, bus.O_REQ}, 32'd0);
    endtask

    initial begin
        logic [31:0] burst_exp [4];
        int          k;
        logic        found;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b0, 32'h0000_1004, 4'b0000, 32'h0, 3, 32'hCAFE_F00D, 32'h0000_1004, 4'b1111, 32'hCAFE_F00D};
        vecs[1] = '{1'b1, 32'h0000_0020, 4'b1100, 32'h1234_5678, 0, 32'h0, 32'h0000_0020, 4'b0011, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_1007, 4'b1010, 32'h0, 1, 32'hA5A5_5A5A, 32'h0000_1004, 4'b0101, 32'hA5A5_5A5A};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 4'b0111, 32'hDEAD_BEEF, 2, 32'h0, 32'hFFFF_FFFC, 4'b1000, 32'h0};

        burst_exp[0] = 32'h0000_0108;
        burst_exp[1] = 32'h0000_010C;
        burst_exp[2] = 32'h0000_0100;
        burst_exp[3] = 32'h0000_0104;

        rst_n           = 1'b0;
        bus.IN_ADS      = 1'b1;
        bus.I_LABS3     = 1'b0;
        bus.IN_LWR      = 1'b1;
        bus.IN_BLAST    = 1'b1;
        bus.IN_LBE      = 4'hF;
        bus.I_LAD       = 32'h0;
        bus.I_REQ_ACK   = 1'b0;
        bus.I_RSP_RDATA = 32'h0;

        tick();
        tick();
        chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            run_single(vecs[i], i);

        // Four-beat read burst with immediate acks; BLAST on the last beat.
        start_cycle(1'b0, 32'h0000_0108, 4'b0000);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk($sformatf("burst%0d_req", b), {31'd0, bus.O_REQ}, 32'd1);
            chk($sformatf("burst%0d_addr", b), bus.O_REQ_ADDR, burst_exp[b]);
            bus.I_REQ_ACK   = 1'b1;
            bus.I_RSP_RDATA = 32'h5000_0000 + b;
            tick();
            bus.I_REQ_ACK   = 1'b0;
            chk($sformatf("burst%0d_readyn", b), {31'd0, bus.ON_READYi}, 32'd0);
            chk($sformatf("burst%0d_lad", b), bus.O_LAD, 32'h5000_0000 + b);
            bus.IN_BLAST = (b == 3) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("burst%0d_readyn_hi", b), {31'd0, bus.ON_READYi}, 32'd1);
        end
        bus.IN_BLAST = 1'b1;
        tick();
        tick();
        chk("burst_done_req", {31'd0, bus.O_REQ}, 32'd0);

        // No ack: beat is force-completed TIMEOUT+1 cycles after O_REQ rises.
        start_cycle(1'b0, 32'h0000_0040, 4'b0000);
        bus.IN_BLAST = 1'b0;
        tick();
        chk("to_req_rise", {31'd0, bus.O_REQ}, 32'd1);
        k     = 0;
        found = 1'b0;
        while (k < 300 && !found) begin
            tick();
            k++;
            if (bus.ON_READYi == 1'b0)
                found = 1'b1;
        end
        chk("to_latency", k, 32'd256);
        chk("to_lad", bus.O_LAD, 32'hFFFF_FFFF);
        chk("to_pulse", {31'd0, bus.O_TIMEOUT}, 32'd1);
        chk("to_oe", {31'd0, bus.O_LAD_OE}, 32'd1);
        tick();
        chk("to_pulse_end", {31'd0, bus.O_TIMEOUT}, 32'd0);
        tick();

        // Ack on the expiry edge: real data, no timeout pulse.
        start_cycle(1'b0, 32'h0000_0080, 4'b0000);
        tick();
        for (int i = 0; i < 255; i++)
            tick();
        chk("tie_pre_readyn", {31'd0, bus.ON_READYi}, 32'd1);
        bus.I_REQ_ACK   = 1'b1;
        bus.I_RSP_RDATA = 32'h600D_DA7A;
        tick();
        bus.I_REQ_ACK   = 1'b0;
        chk("tie_readyn", {31'd0, bus.ON_READYi}, 32'd0);
        chk("tie_pulse", {31'd0, bus.O_TIMEOUT}, 32'd0);
        chk("tie_lad", bus.O_LAD, 32'h600D_DA7A);
        tick();
        tick();

        // ADS without board select is not claimed.
        bus.IN_ADS  = 1'b0;
        bus.I_LABS3 = 1'b0;
        bus.I_LAD   = 32'h0000_999C;
        tick();
        bus.IN_ADS  = 1'b1;
        tick();
        chk("desel_req", {31'd0, bus.O_REQ}, 32'd0);
        chk("desel_addr", bus.O_REQ_ADDR, 32'h0000_0080);

        // ADS during REQ, READY and RECOVER is ignored.
        start_cycle(1'b0, 32'h0000_0300, 4'b0000);
        tick();
        bus.IN_ADS = 1'b0;
        bus.I_LAD  = 32'h0000_ABC0;
        tick();
        bus.IN_ADS = 1'b1;
        chk("viol_req", {31'd0, bus.O_REQ}, 32'd1);
        chk("viol_addr", bus.O_REQ_ADDR, 32'h0000_0300);
        bus.I_REQ_ACK   = 1'b1;
        bus.I_RSP_RDATA = 32'h0BAD_F00D;
        tick();
        bus.I_REQ_ACK = 1'b0;
        bus.IN_BLAST  = 1'b0;
        tick();
        bus.IN_ADS = 1'b0;
        bus.I_LAD  = 32'h0000_7770;
        tick();
        bus.IN_ADS = 1'b1;
        tick();
        chk("recov_ads_req", {31'd0, bus.O_REQ}, 32'd0);
        chk("recov_ads_addr", bus.O_REQ_ADDR, 32'h0000_0300);
        bus.IN_BLAST = 1'b1;

        // Reset while beat 2 of a burst is in REQ.
        start_cycle(1'b0, 32'h0000_0200, 4'b0000);
        tick();
        bus.I_REQ_ACK   = 1'b1;
        bus.I_RSP_RDATA = 32'h1111_2222;
        tick();
        bus.I_REQ_ACK = 1'b0;
        tick();
        tick();
        chk("mid_req", {31'd0, bus.O_REQ}, 32'd1);
        chk("mid_addr", bus.O_REQ_ADDR, 32'h0000_0204);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_single(vecs[0], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
